// File: rtl/flappy_pkg.sv
// Shared constants, types and column helpers for the Flappy Bird pipe field.
// The field is a ROWS x COLS bitmap; a pipe column is all rows set except a GAP-tall opening.
package flappy_pkg;
   localparam int ROWS     = 16;
   localparam int COLS     = 16;
   localparam int GAP      = 4;
   localparam int SPACING  = 4;
   localparam int BIRD_COL = 3;

   localparam int ROW_W = $clog2(ROWS);
   localparam int CNT_W = $clog2(SPACING) + 1;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   typedef enum logic [1:0] {IDLE, RUN, FROZEN} scroll_state_t;
   typedef logic [COLS-1:0] row_t;
   typedef logic [ROWS-1:0] col_t;

   // Raw values past the last legal gap position wrap back to the top of the range.
   function automatic logic [ROW_W-1:0] gap_select(input logic [ROW_W-1:0] raw);
      if (raw <= ROW_W'(ROWS - GAP)) return raw;
      else return raw - ROW_W'(ROWS - GAP + 1);
   endfunction

   function automatic col_t pipe_column(input logic [ROW_W-1:0] gap_top);
      col_t mask;
      for (int r = 0; r < ROWS; r++) begin
         mask[r] = !((r >= int'(gap_top)) && (r < int'(gap_top) + GAP));
      end
      return mask;
   endfunction
endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), shifting left with the feedback bit at the LSB.
module lfsr8
   import flappy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] q
);
   logic [7:0] r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_q <= LFSR_SEED;
      else        r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
   end

   assign q = r_q;
endmodule

// File: rtl/pipe_scroller.sv
// Pipe obstacle field: scrolls one column left per tick and inserts a random-gap pipe every SPACING ticks.
// state  | meaning
// IDLE   | game not running, field empty
// RUN    | field scrolls on tick
// FROZEN | game over, field and gap held, tick ignored
module pipe_scroller
   import flappy_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick,
   input  logic                   enable,
   input  logic                   freeze,
   output logic [ROWS*COLS-1:0]   grid,
   output logic                   pipe_passed,
   output logic [ROW_W-1:0]       gap_top
);
   scroll_state_t          r_state;
   scroll_state_t          w_state_next;
   logic [7:0]             w_lfsr;
   logic [ROWS*COLS-1:0]   r_grid;
   logic [CNT_W-1:0]       r_space_cnt;
   logic                   r_pipe_passed;
   logic [ROW_W-1:0]       r_gap_top;
   logic                   w_scroll;
   logic                   w_clear;
   logic                   w_insert;
   logic                   w_bird_busy;
   logic [ROW_W-1:0]       w_gap_new;
   col_t                   w_new_col;
   logic                   w_lfsr_unused;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (w_lfsr)
   );

   assign w_lfsr_unused = ^w_lfsr[7:ROW_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Dropping enable always wins, so a simultaneous tick never reaches the field.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (enable) w_state_next = RUN;
         RUN: begin
            if (!enable)     w_state_next = IDLE;
            else if (freeze) w_state_next = FROZEN;
         end
         FROZEN: begin
            if (!enable)      w_state_next = IDLE;
            else if (!freeze) w_state_next = RUN;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_scroll = (r_state == RUN) && enable && !freeze && tick;
      w_clear  = (w_state_next == IDLE);
   end

   assign w_insert  = (r_space_cnt == '0);
   assign w_gap_new = gap_select(w_lfsr[ROW_W-1:0]);
   assign w_new_col = w_insert ? pipe_column(w_gap_new) : '0;

   always_comb begin
      w_bird_busy = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         w_bird_busy = w_bird_busy | r_grid[r*COLS + BIRD_COL];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_grid        <= '0;
         r_space_cnt   <= '0;
         r_pipe_passed <= 1'b0;
         r_gap_top     <= '0;
      end else if (w_clear) begin
         r_grid        <= '0;
         r_space_cnt   <= '0;
         r_pipe_passed <= 1'b0;
      end else if (w_scroll) begin
         for (int r = 0; r < ROWS; r++) begin
            r_grid[r*COLS +: COLS] <= {w_new_col[r], r_grid[r*COLS+1 +: COLS-1]};
         end
         if (w_insert) begin
            r_space_cnt <= CNT_W'(SPACING - 1);
            r_gap_top   <= w_gap_new;
         end else begin
            r_space_cnt <= r_space_cnt - CNT_W'(1);
         end
         r_pipe_passed <= w_bird_busy;
      end else begin
         r_pipe_passed <= 1'b0;
      end
   end

   assign grid        = r_grid;
   assign pipe_passed = r_pipe_passed;
   assign gap_top     = r_gap_top;
endmodule

// File: tb/tb_pipe_scroller.sv
// Directed plus randomized bench for pipe_scroller against a column-list reference model.
module tb_pipe_scroller;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         tick = 1'b0;
   logic         enable = 1'b0;
   logic         freeze = 1'b0;
   logic [255:0] grid;
   logic         pipe_passed;
   logic [3:0]   gap_top;

   int vectors = 0;
   int miscompares = 0;

   pipe_scroller dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .enable      (enable),
      .freeze      (freeze),
      .grid        (grid),
      .pipe_passed (pipe_passed),
      .gap_top     (gap_top)
   );

   always #5 clk = ~clk;

   // reference LFSR sequence: feedback = xor of bits 7,5,4,3
   logic [7:0] m_lfsr;
   always @(posedge clk or negedge reset) begin
      if (!reset) m_lfsr <= 8'hA5;
      else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
   end

   logic [15:0] m_col [16];
   int          m_mode;     // 0 idle, 1 run, 2 frozen
   int          m_ticks;
   int          m_inserts;
   logic        m_passed;
   logic [3:0]  m_gap;

   function automatic logic [15:0] pipe_col(input logic [3:0] g);
      logic [15:0] hole;
      hole = 16'hF << g;
      return ~hole;
   endfunction

   function automatic logic [255:0] exp_grid();
      logic [255:0] g;
      g = '0;
      for (int c = 0; c < 16; c++)
         for (int r = 0; r < 16; r++)
            g[r*16 + c] = m_col[c][r];
      return g;
   endfunction

   function automatic logic [15:0] col_of(input logic [255:0] g, input int c);
      logic [15:0] v;
      for (int r = 0; r < 16; r++) v[r] = g[r*16 + c];
      return v;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < 16; c++) m_col[c] = '0;
      m_ticks = 0;
   endtask

   task automatic model_edge(input logic t, input logic e, input logic f, input logic [7:0] lf);
      m_passed = 1'b0;
      case (m_mode)
         0: begin
            model_clear();
            if (e) m_mode = 1;
         end
         1: begin
            if (!e) begin model_clear(); m_mode = 0; end
            else if (f) m_mode = 2;
            else if (t) begin
               m_passed = (m_col[3] != 16'h0);
               for (int c = 0; c < 15; c++) m_col[c] = m_col[c+1];
               if (m_ticks % 4 == 0) begin
                  m_gap = 4'(lf[3:0] % 13);
                  m_col[15] = pipe_col(m_gap);
                  m_inserts++;
               end else begin
                  m_col[15] = '0;
               end
               m_ticks++;
            end
         end
         default: begin
            if (!e) begin model_clear(); m_mode = 0; end
            else if (!f) m_mode = 1;
         end
      endcase
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // caller sits just after a rising edge; inputs apply to the next edge
   task automatic step(input logic t, input logic e, input logic f);
      logic [7:0] lf;
      tick = t; enable = e; freeze = f;
      lf = m_lfsr;
      @(posedge clk);
      model_edge(t, e, f, lf);
      #1;
      check("grid", grid, exp_grid());
      check("pipe_passed", 256'(pipe_passed), 256'(m_passed));
      check("gap_top", 256'(gap_top), 256'(m_gap));
   endtask

   task automatic model_reset();
      model_clear();
      m_mode = 0; m_passed = 1'b0; m_gap = '0;
   endtask

   initial begin
      logic [255:0] frozen_grid;
      int passes;
      m_inserts = 0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_grid", grid, '0);
      check("rst_passed", 256'(pipe_passed), 256'(0));
      check("rst_gap", 256'(gap_top), 256'(0));
      check("rst_lfsr", 256'(dut.w_lfsr), 256'(8'hA5));
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // tick in idle is ignored, then enter RUN
      step(1, 0, 0);
      step(0, 1, 0);

      // first pipe lands at column 15 only
      step(1, 1, 0);
      check("first_col15", 256'(col_of(grid, 15)), 256'(pipe_col(m_gap)));
      check("first_col14", 256'(col_of(grid, 14)), 256'(0));
      for (int i = 0; i < 3; i++) step(1, 1, 0);
      check("after4_col12", 256'(col_of(grid, 12) != 16'h0), 256'(1));
      check("after4_col15", 256'(col_of(grid, 15)), 256'(0));

      // spacing: 12 ticks -> pipes at 4, 8, 12
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 1) step(0, 1, 0);
         step(1, 1, 0);
      end
      check("spc_col4", 256'(col_of(grid, 4) != 16'h0), 256'(1));
      check("spc_col8", 256'(col_of(grid, 8) != 16'h0), 256'(1));
      check("spc_col12", 256'(col_of(grid, 12) != 16'h0), 256'(1));
      check("spc_col15", 256'(col_of(grid, 15)), 256'(0));

      // pass pulse: 13th tick brings the first pipe to column 3, 14th passes it
      step(1, 1, 0);
      check("pass_pre", 256'(pipe_passed), 256'(0));
      step(1, 1, 0);
      check("pass_pulse", 256'(pipe_passed), 256'(1));
      check("pass_col2", 256'(col_of(grid, 2) != 16'h0), 256'(1));
      step(0, 1, 0);
      check("pass_single", 256'(pipe_passed), 256'(0));

      // randomized run over 200 insertions, tick sometimes held high
      m_inserts = 0;
      passes = 0;
      while (m_inserts < 200) begin
         repeat ($urandom_range(0, 2)) step(0, 1, 0);
         step(1, 1, 0);
         if (m_passed) passes++;
         check("gap_range", 256'(gap_top <= 4'd12), 256'(1));
      end
      check("passes_seen", 256'(passes > 100), 256'(1));

      // freeze with tick: field held for 20 ticks
      frozen_grid = grid;
      step(1, 1, 1);
      for (int i = 0; i < 20; i++) step(1, 1, 1);
      check("frz_grid", grid, frozen_grid);
      step(0, 1, 0);
      step(1, 1, 0);

      // enable drops with a tick: idle wins
      step(1, 0, 0);
      check("idle_grid", grid, '0);
      step(0, 0, 0);
      step(0, 1, 0);
      step(1, 1, 0);
      check("reen_col15", 256'(col_of(grid, 15)), 256'(pipe_col(m_gap)));

      // async reset mid-run, no edge needed
      repeat (5) step(1, 1, 0);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("arst_grid", grid, '0);
      check("arst_passed", 256'(pipe_passed), 256'(0));
      check("arst_gap", 256'(gap_top), 256'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("arst_lfsr", 256'(dut.w_lfsr), 256'(8'hA5));
      @(posedge clk);
      #1;
      step(0, 1, 0);
      step(1, 1, 0);
      repeat (6) step($urandom_range(0, 1) == 1, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
